// File: rtl/vram_scan.sv
// Scanline VRAM fetcher: 2-word prefetch FIFO feeding a 1bpp pixel shifter.
// Define VSCAN_PIXDBL_EN to hold each pixel for two strobes (horizontal doubling).
module vram_scan #(
    parameter logic [13:0] BASE       = 14'h0000,
    parameter int          LINE_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        active,
    input  logic        pix_en,
    output logic        vram_req,
    input  logic        vram_gnt,
    output logic [13:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic        pixel,
    output logic        underrun
);

    localparam logic [7:0]  LW     = 8'(LINE_WORDS);
    localparam logic [13:0] LW14   = 14'(LINE_WORDS);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_REQ  = 2'd1;
    localparam logic [1:0]  S_DATA = 2'd2;

    logic [1:0]  r_state;
    logic [13:0] r_line_ptr;
    logic [13:0] r_addr;
    logic        r_first;
    logic [7:0]  r_fcnt;
    logic [7:0]  r_wcnt;
    logic [15:0] r_fifo [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;
    logic [15:0] r_sr;
    logic [4:0]  r_bits;
    logic        r_pixel;
    logic        r_underrun;

    logic        w_strobe;
    logic        w_shift;
    logic        w_room;
    logic        w_fetch;
    logic        w_grant;
    logic        w_wr;
    logic        w_empty;
    logic        w_need;
    logic        w_rd;
    logic        w_starve;
    logic [15:0] w_head;

    assign w_strobe = pix_en & active & ~line_start;
    assign w_empty  = (r_cnt == 2'd0);
    assign w_head   = r_fifo[r_rp];
    assign w_need   = w_strobe & (r_bits == 5'd0) & (r_wcnt < LW);
    assign w_rd     = w_need & ~w_empty;
    assign w_starve = w_strobe & (r_bits == 5'd0) & ~w_rd;
    assign w_room   = (r_cnt + {1'b0, r_state == S_DATA}) < 2'd2;
    assign w_fetch  = w_room & (r_fcnt < LW);
    assign w_grant  = (r_state == S_REQ) & vram_gnt;
    assign w_wr     = (r_state == S_DATA) & ~line_start;

`ifdef VSCAN_PIXDBL_EN
    logic r_phase;

    // Second strobe of a pair shifts; a starved strobe keeps the pairing intact.
    assign w_shift = w_strobe & r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_phase <= 1'b0;
        else if (line_start)
            r_phase <= 1'b0;
        else if (w_strobe & ~w_starve)
            r_phase <= ~r_phase;
    end
`else
    assign w_shift = w_strobe;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_ptr <= BASE;
            r_first    <= 1'b1;
        end else if (frame_start) begin
            r_line_ptr <= BASE;
            r_first    <= ~line_start;
        end else if (line_start) begin
            if (r_first)
                r_first <= 1'b0;
            else
                r_line_ptr <= r_line_ptr + LW14;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= 14'd0;
            r_fcnt  <= LW;
        end else if (line_start) begin
            r_state <= S_IDLE;
            r_fcnt  <= 8'd0;
        end else begin
            if (w_grant)
                r_fcnt <= r_fcnt + 8'd1;
            case (r_state)
                S_IDLE, S_DATA: begin
                    if (w_fetch) begin
                        r_state <= S_REQ;
                        r_addr  <= r_line_ptr + {6'd0, r_fcnt};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (vram_gnt)
                        r_state <= S_DATA;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_fifo[r_wp] <= vram_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else if (line_start) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_wr)
                r_wp <= ~r_wp;
            if (w_rd)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr       <= 16'd0;
            r_bits     <= 5'd0;
            r_wcnt     <= LW;
            r_pixel    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (frame_start)
                r_underrun <= 1'b0;
            else if (w_need & w_empty)
                r_underrun <= 1'b1;

            // Unshifted load leaves 16 bits so the paired strobe can shift.
            if (line_start) begin
                r_sr   <= 16'd0;
                r_bits <= 5'd0;
                r_wcnt <= 8'd0;
            end else if (w_rd) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (w_shift) begin
                    r_sr   <= {w_head[14:0], 1'b0};
                    r_bits <= 5'd15;
                end else begin
                    r_sr   <= w_head;
                    r_bits <= 5'd16;
                end
            end else if (w_shift && r_bits != 5'd0) begin
                r_sr   <= {r_sr[14:0], 1'b0};
                r_bits <= r_bits - 5'd1;
            end

            if (!active)
                r_pixel <= 1'b0;
            else if (w_starve)
                r_pixel <= 1'b0;
            else if (w_rd)
                r_pixel <= w_head[15];
            else if (w_strobe)
                r_pixel <= r_sr[15];
        end
    end

    assign vram_req  = (r_state == S_REQ);
    assign vram_addr = r_addr;
    assign pixel     = r_pixel;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_vram_scan.sv
// Bench for vram_scan: table vectors, corner sequences, randomized lines
// checked against a queue-based pixel model and an address model.
module tb_vram_scan;

    localparam logic [13:0] BASEV = 14'h0000;
    localparam int          LWV   = 2;
`ifdef VSCAN_PIXDBL_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        line_start;
    logic        active;
    logic        pix_en;
    logic        vram_req;
    logic        vram_gnt;
    logic [13:0] vram_addr;
    logic [15:0] vram_data;
    logic        pixel;
    logic        underrun;

    vram_scan #(.BASE(BASEV), .LINE_WORDS(LWV)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .line_start (line_start),
        .active     (active),
        .pix_en     (pix_en),
        .vram_req   (vram_req),
        .vram_gnt   (vram_gnt),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .pixel      (pixel),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] vmem [64];
    logic [13:0] grants [$];
    bit          qbits [$];
    int          idx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Acts as the arbiter/VRAM: a grant returns data the following cycle.
    task automatic tick();
        logic        g;
        logic [13:0] a;
        g = vram_req & vram_gnt;
        a = vram_addr;
        @(posedge clk);
        #1;
        if (g) begin
            grants.push_back(a);
            vram_data = vmem[a[5:0]];
        end else begin
            vram_data = 16'($urandom);
        end
    endtask

    function automatic logic [13:0] cur_ptr();
        return BASEV + 14'(LWV * idx);
    endfunction

    task automatic pulse(input bit fs, input bit ls);
        frame_start = fs;
        line_start  = ls;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        if (fs) idx = -1;
        if (ls) begin
            idx++;
            grants.delete();
        end
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1);
        logic [13:0] p0;
        logic [13:0] p1;
        p0 = cur_ptr();
        p1 = p0 + 14'd1;
        vmem[p0[5:0]] = w0;
        vmem[p1[5:0]] = w1;
    endtask

    task automatic fill(input bit rnd, input string nm);
        int n;
        int waitc;
        n = 0;
        waitc = 0;
        while (grants.size() < LWV && n < 100) begin
            vram_gnt = rnd ? (($urandom_range(0, 1) == 1) || waitc >= 3) : 1'b1;
            if (vram_req && !vram_gnt) waitc++;
            else waitc = 0;
            tick();
            n++;
        end
        chk({nm, "_nreq"}, grants.size(), LWV);
        if (grants.size() >= 2) begin
            chk({nm, "_addr0"}, grants[0], cur_ptr());
            chk({nm, "_addr1"}, grants[1], cur_ptr() + 14'd1);
        end
        vram_gnt = 1'b1;
        repeat (3) tick();
        chk({nm, "_reqlow"}, vram_req, 1'b0);
    endtask

    task automatic load_model();
        logic [13:0] p;
        logic [15:0] w;
        qbits.delete();
        for (int i = 0; i < LWV; i++) begin
            p = cur_ptr() + 14'(i);
            w = vmem[p[5:0]];
            for (int b = 15; b >= 0; b--)
                for (int r = 0; r < REP; r++)
                    qbits.push_back(w[b]);
        end
    endtask

    task automatic run_pix(input bit rnd, input int nstr, input string nm);
        int   done;
        int   guard;
        int   kind;
        logic expv;
        logic last;
        active = 1'b0;
        pix_en = 1'b0;
        tick();
        chk({nm, "_inact"}, pixel, 1'b0);
        last  = 1'b0;
        done  = 0;
        guard = 0;
        while (done < nstr && guard < 1000) begin
            kind = rnd ? $urandom_range(0, 4) : 0;
            if (kind <= 2) begin
                active = 1'b1;
                pix_en = 1'b1;
                expv   = (qbits.size() > 0) ? qbits.pop_front() : 1'b0;
                last   = expv;
                done++;
            end else if (kind == 3) begin
                active = 1'b1;
                pix_en = 1'b0;
                expv   = last;
            end else begin
                active = 1'b0;
                pix_en = 1'b1;
                expv   = 1'b0;
                last   = 1'b0;
            end
            tick();
            chk({nm, "_pix"}, pixel, expv);
            guard++;
        end
        active = 1'b0;
        pix_en = 1'b0;
        tick();
        chk({nm, "_undr"}, underrun, 1'b0);
        chk({nm, "_nreq_end"}, grants.size(), LWV);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [4];
        logic [15:0] wa;
        logic [15:0] wb;
        int          r;
        logic        e;
        tbl[0] = '{16'hA5F0, 16'h0001, 32'hA5F0_0001};
        tbl[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        tbl[2] = '{16'h8000, 16'h0001, 32'h8000_0001};
        tbl[3] = '{16'h1234, 16'hFEDC, 32'h1234_FEDC};
        for (int i = 0; i < 64; i++) vmem[i] = 16'($urandom);

        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        active = 1'b0; pix_en = 1'b0; vram_gnt = 1'b1; vram_data = 16'd0;
        idx = -1;
        repeat (3) tick();
        chk("rst_req", vram_req, 1'b0);
        chk("rst_addr", vram_addr, 14'd0);
        chk("rst_pix", pixel, 1'b0);
        chk("rst_undr", underrun, 1'b0);
        reset = 1'b0;
        active = 1'b1; pix_en = 1'b1;
        repeat (5) tick();
        active = 1'b0; pix_en = 1'b0;
        chk("nofetch_before_line", grants.size(), 0);
        chk("nofetch_undr", underrun, 1'b0);

        // Table vectors: consecutive lines of one frame
        pulse(1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            pulse(1'b0, 1'b1);
            set_words(tbl[t].w0, tbl[t].w1);
            fill(1'b0, "tbl");
            active = 1'b1;
            pix_en = 1'b1;
            for (int s = 0; s < 32 * REP + 4; s++) begin
                tick();
                e = (s < 32 * REP) ? tbl[t].exp[31 - s / REP] : 1'b0;
                chk("tbl_pix", pixel, e);
            end
            active = 1'b0;
            pix_en = 1'b0;
            tick();
            chk("tbl_undr", underrun, 1'b0);
        end

        // line_start in the DATA cycle drops the returned word
        pulse(1'b1, 1'b1);
        vram_gnt = 1'b1;
        r = 0;
        while (grants.size() < 1 && r < 20) begin
            tick();
            r++;
        end
        chk("drop_grant_seen", grants.size(), 1);
        chk("drop_req_after_gnt", vram_req, 1'b0);
        vram_data   = 16'hDEAD;
        line_start  = 1'b1;
        tick();
        line_start  = 1'b0;
        idx++;
        grants.delete();
        set_words(16'h0F0F, 16'hC003);
        fill(1'b0, "drop");
        load_model();
        run_pix(1'b0, 32 * REP + 4, "drop");

        // Randomized lines and frames
        for (int ln = 0; ln < 12; ln++) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin
                pulse(1'b1, 1'b0);
                pulse(1'b0, 1'b1);
            end else if (r == 1) begin
                pulse(1'b1, 1'b1);
            end else begin
                pulse(1'b0, 1'b1);
            end
            wa = 16'($urandom);
            wb = 16'($urandom);
            set_words(wa, wb);
            load_model();
            fill(1'b1, "rnd");
            run_pix(1'b1, 32 * REP + 6, "rnd");
        end

        // Starved fetch: underrun is sticky until frame_start
        pulse(1'b1, 1'b1);
        vram_gnt = 1'b0;
        active = 1'b1;
        pix_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("starve_pix", pixel, 1'b0);
            chk("starve_undr", underrun, 1'b1);
        end
        chk("starve_req_held", vram_req, 1'b1);
        chk("starve_addr_held", vram_addr, cur_ptr());
        active = 1'b0;
        pix_en = 1'b0;
        vram_gnt = 1'b1;
        repeat (5) tick();
        chk("undr_sticky", underrun, 1'b1);
        pulse(1'b0, 1'b1);
        chk("undr_sticky_line", underrun, 1'b1);
        pulse(1'b1, 1'b0);
        chk("undr_clr_frame", underrun, 1'b0);

        // Reset while a request is pending
        pulse(1'b1, 1'b1);
        vram_gnt = 1'b0;
        r = 0;
        while (!vram_req && r < 10) begin
            tick();
            r++;
        end
        chk("midrst_req_before", vram_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_req_now", vram_req, 1'b0);
        chk("midrst_addr_now", vram_addr, 14'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idx = -1;
        grants.delete();
        vram_gnt = 1'b1;
        repeat (5) tick();
        chk("midrst_no_req", grants.size(), 0);
        chk("midrst_req_low", vram_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_scan.md
VRAM_SCAN -- requirements
Module: vram_scan

Interface
REQ-001 Parameter BASE, default 14'h0000, VRAM word address of the first pixel word in a frame.
REQ-002 Parameter LINE_WORDS, default 20, number of 16-bit words per active line (1..255).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-006 line_start  input  1  one-cycle pulse before each active line.
REQ-007 active  input  1  high during visible pixels.
REQ-008 pix_en  input  1  pixel strobe; one pixel is consumed per strobe while active.
REQ-009 vram_req  output  1  read request to the VRAM arbiter.
REQ-010 vram_gnt  input  1  arbiter accepts the request this cycle.
REQ-011 vram_addr  output  14  VRAM word address, held stable while vram_req is high.
REQ-012 vram_data  input  16  VRAM word data, valid the cycle after a granted request.
REQ-013 pixel  output  1  serialized 1bpp pixel, registered.
REQ-014 underrun  output  1  sticky flag: a pixel was needed while no word was available.

Function
REQ-015 line_ptr SHALL load BASE on frame_start, and SHALL advance by LINE_WORDS on every line_start except the first one after frame_start; arithmetic is modulo 2^14.
REQ-016 line_start SHALL clear fetch count, FIFO, shift register and any in-flight read; returning data from a discarded read SHALL be dropped.
REQ-017 frame_start coincident with line_start: frame_start SHALL take priority; line_ptr = BASE and the line-start clear SHALL also apply.
REQ-018 Fetch FSM states: IDLE, REQ, DATA. IDLE->REQ when fetch count < LINE_WORDS and FIFO count + in-flight < 2. REQ->DATA on vram_gnt. DATA->REQ or IDLE next cycle, per the IDLE condition.
REQ-019 In REQ, vram_req SHALL be 1 and vram_addr SHALL equal line_ptr + fetch count; vram_req SHALL drop the cycle after the grant.
REQ-020 vram_data SHALL be written into the FIFO in the cycle after the grant (DATA state); fetch count increments on grant.
REQ-021 FIFO: 2 entries x 16 bits; write and read in the same cycle SHALL both occur; writes never occur when full (guaranteed by REQ-018).
REQ-022 Shift register: on pix_en & active, pixel <= bit 15 and shift left; after the 16th bit the next word SHALL load from the FIFO in the same cycle.
REQ-023 The first word of a line SHALL be loaded from the FIFO on the first pix_en & active of that line, with no extra latency.
REQ-024 If a load is needed and the FIFO is empty, pixel <= 0 and underrun <= 1; underrun SHALL clear only on frame_start or reset.
REQ-025 When active is low, pixel SHALL be 0 from the next clock; pix_en while inactive SHALL not shift.
REQ-026 Words beyond LINE_WORDS SHALL never be requested; pixels past the line end SHALL output 0 without setting underrun.

Reset
REQ-027 On reset: vram_req=0, vram_addr=0, pixel=0, underrun=0, FSM=IDLE, FIFO empty, line_ptr=BASE, fetch count=LINE_WORDS (no fetch until line_start).
REQ-028 Reset asserted mid-fetch SHALL abandon the request immediately; no FIFO write SHALL follow.

Configuration
REQ-029 Macro VSCAN_PIXDBL_EN defined: each bit SHALL be held for two consecutive pix_en & active strobes (horizontal doubling), and the shift SHALL occur on every second strobe; the strobe phase SHALL clear on line_start.
REQ-030 Macro undefined: one bit per strobe, as in REQ-022.

Verification
REQ-031 Reset, frame_start, line_start, gnt tied high, BASE=0, LINE_WORDS=2 -> requests to addresses 0 and 1 only; FIFO holds 2 words; vram_req low afterwards.
REQ-032 Words 16'hA5F0 and 16'h0001, 32 strobes -> pixel sequence 1010010111110000 then 0000000000000001; underrun=0.
REQ-033 Second line_start -> first request at address LINE_WORDS (2); frame_start + line_start together -> request at address 0.
REQ-034 gnt held low for 40 cycles while strobing -> pixel=0 and underrun=1 after first strobe; stays 1 until the next frame_start.
REQ-035 line_start on the DATA-state cycle -> the returned word is not written to the FIFO; the next request uses the new line's address.
REQ-036 With VSCAN_PIXDBL_EN, word 16'h8000 -> pixel 1 for strobes 1-2, 0 for strobes 3-32; next word loaded on strobe 33.
